// File: rtl/mccoy_seq_pkg.sv
// mccoy_seq_pkg: shared types and constants for the McCoy program sequencer.
package mccoy_seq_pkg;

    localparam int INSTR_W = 6;
    localparam int OUT_W   = 8;
    localparam int REPS_W  = 4;

    // Low three bits of an instruction select the core operation.
    localparam logic [2:0] OP_LI  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        CAP
    } seq_state_e;

endpackage

// File: rtl/mccoy_prog_buf.sv
// mccoy_prog_buf: DEPTH x INSTR_W program store, one write port, one async read
// port. Contents are deliberately not reset; they are only read after being written.
module mccoy_prog_buf
    import mccoy_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  instr_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output instr_t                   rdata
);

    instr_t mem [DEPTH];

    // Host write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mccoy_prog_sequencer.sv
// mccoy_prog_sequencer: loads a short program from the host, then resets the
// McCoy core, streams the program (reps+1 times) and captures the core output.
// Optional feature: define MCCOY_SEQ_STEP_EN to add a 'step' input that gates
// each instruction issue during RUN.
module mccoy_prog_sequencer
    import mccoy_seq_pkg::*;
#(
    parameter int     DEPTH     = 16,
    parameter instr_t NOP_INSTR = 6'b000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_valid,
    input  instr_t            load_instr,
    output logic              load_ready,
    input  logic              clear,
    input  logic              start,
    input  logic [REPS_W-1:0] reps,
    input  logic              abort,
`ifdef MCCOY_SEQ_STEP_EN
    input  logic              step,
`endif
    output instr_t            core_instr,
    output logic              core_reset,
    input  logic [OUT_W-1:0]  core_out,
    output logic              busy,
    output logic [OUT_W-1:0]  result,
    output logic              result_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    seq_state_e        state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [AW-1:0]     pc;       // next buffer entry to issue
    logic [REPS_W-1:0] rep;      // remaining repeats after the current pass
    logic              last;     // final instruction of the run is on core_instr
    logic              load_acc;
    logic              start_go;
    logic              wrap;
    logic              issue;
    instr_t            rd_instr;

    assign load_ready = (state == IDLE) && (count != CW'(DEPTH)) && !clear;
    assign load_acc   = load_valid && load_ready;

    // Clear beats a same-cycle load; a start sees the count after any same-cycle write.
    assign count_nxt  = (clear && state == IDLE) ? '0 : count + CW'(load_acc);
    assign start_go   = (state == IDLE) && start && !abort && (count_nxt != '0);
    assign wrap       = ({1'b0, pc} == count - CW'(1));

`ifdef MCCOY_SEQ_STEP_EN
    assign issue = step;
`else
    assign issue = 1'b1;
`endif

    mccoy_prog_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .we    (load_acc),
        .waddr (count[AW-1:0]),
        .wdata (load_instr),
        .raddr (pc),
        .rdata (rd_instr)
    );

    // Program length; buffer contents survive runs, only clear or reset empty it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= count_nxt;
    end

    // Sequencer FSM; outputs are registered for the cycle the new state occupies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= '0;
            rep          <= '0;
            last         <= 1'b0;
            core_instr   <= NOP_INSTR;
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            core_instr   <= NOP_INSTR;
            core_reset   <= 1'b0;
            result_valid <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_go) begin
                            state      <= CLR;
                            busy       <= 1'b1;
                            core_reset <= 1'b1;
                            pc         <= '0;
                            rep        <= reps;
                            last       <= 1'b0;
                        end
                    end
                    // CLR hands straight into the first issue so RUN has no bubble.
                    CLR, RUN: begin
                        state <= RUN;
                        if (last) begin
                            state <= CAP;
                            last  <= 1'b0;
                        end else if (issue) begin
                            core_instr <= rd_instr;
                            if (wrap) begin
                                pc <= '0;
                                if (rep == '0) last <= 1'b1;
                                else           rep  <= rep - REPS_W'(1);
                            end else begin
                                pc <= pc + AW'(1);
                            end
                        end
                    end
                    CAP: begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result       <= core_out;
                        result_valid <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mccoy_prog_sequencer.sv
// tb_mccoy_prog_sequencer: directed + randomized bench with a behavioural McCoy
// core attached to the sequencer and an ISA-level reference for the results.
module tb_mccoy_prog_sequencer;
    import mccoy_seq_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [5:0] NOP   = 6'b000000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid, clear, start, abort;
    logic [5:0] load_instr;
    logic [3:0] reps;
    logic       load_ready, core_reset, busy, result_valid;
    logic [5:0] core_instr;
    logic [7:0] core_out, result;
`ifdef MCCOY_SEQ_STEP_EN
    logic       step = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    logic [5:0] prog [$];                       // expected buffer contents
    logic [7:0] m_acc = 8'h00;                  // reference core state
    logic [7:0] m_x [8] = '{default: 8'h00};
    logic [7:0] last_res = 8'h00;
    logic [7:0] c_acc = 8'h00;                  // behavioural core state
    logic [7:0] c_x [8] = '{default: 8'h00};

    mccoy_prog_sequencer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_instr   (load_instr),
        .load_ready   (load_ready),
        .clear        (clear),
        .start        (start),
        .reps         (reps),
        .abort        (abort),
`ifdef MCCOY_SEQ_STEP_EN
        .step         (step),
`endif
        .core_instr   (core_instr),
        .core_reset   (core_reset),
        .core_out     (core_out),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Behavioural core: executes whatever is on core_instr each clock.
    always @(posedge clk) begin
        case (core_instr[2:0])
            OP_LI:   c_acc <= {{5{core_instr[5]}}, core_instr[5:3]};
            OP_ADD:  c_acc <= c_acc + c_x[core_instr[5:3]];
            OP_SR:   c_x[core_instr[5:3]] <= c_acc;
            OP_NOT:  c_acc <= ~c_acc;
            default: ;
        endcase
    end
    assign core_out = c_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ref_exec(input logic [5:0] ins);
        if (ins[2:0] == OP_LI)       m_acc = {{5{ins[5]}}, ins[5:3]};
        else if (ins[2:0] == OP_ADD) m_acc = m_acc + m_x[ins[5:3]];
        else if (ins[2:0] == OP_SR)  m_x[ins[5:3]] = m_acc;
        else if (ins[2:0] == OP_NOT) m_acc = ~m_acc;
    endtask

    function automatic logic [5:0] rnd_ins();
        logic [2:0] op;
        case ($urandom_range(3))
            0:       op = OP_LI;
            1:       op = OP_ADD;
            2:       op = OP_SR;
            default: op = OP_NOT;
        endcase
        return {3'($urandom_range(7)), op};
    endfunction

    task automatic load1(input logic [5:0] ins);
        load_valid = 1'b1;
        load_instr = ins;
        #1;
        chk("load_ready", 32'(load_ready), 32'(prog.size() < DEPTH));
        if (prog.size() < DEPTH) prog.push_back(ins);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prog.delete();
    endtask

    // Start a run and follow it cycle by cycle up to the captured result.
    task automatic run(input string tag, input logic [3:0] r, input bit with_load, input logic [5:0] ld);
        logic [5:0] want [$];
        int bad;
        start = 1'b1;
        reps  = r;
        if (with_load) begin
            load_valid = 1'b1;
            load_instr = ld;
            if (prog.size() < DEPTH) prog.push_back(ld);
        end
        tick();
        start = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k <= int'(r); k++)
            foreach (prog[i]) want.push_back(prog[i]);
        chk({tag, "/clr"}, 32'({busy, core_reset, core_instr}), 32'({1'b1, 1'b1, NOP}));
        bad = 0;
        foreach (want[k]) begin
            tick();
            if (core_instr !== want[k] || core_reset !== 1'b0 || busy !== 1'b1) bad++;
            ref_exec(want[k]);
        end
        chk({tag, "/issue"}, 32'(bad), 32'(0));
        tick();
        chk({tag, "/cap"}, 32'({busy, result_valid, core_instr}), 32'({1'b1, 1'b0, NOP}));
        tick();
        chk({tag, "/res"}, 32'({busy, result_valid, result}), 32'({1'b0, 1'b1, m_acc}));
        last_res = m_acc;
        tick();
        chk({tag, "/hold"}, 32'({result_valid, result}), 32'({1'b0, last_res}));
    endtask

    initial begin
        logic [5:0] s1 [6];
        logic [5:0] s2 [3];
        int bad;
        int len;
        bit wl;
        s1 = '{6'b011001, 6'b010110, 6'b100001, 6'b011110, 6'b010001, 6'b010011};
        s2 = '{6'b011001, 6'b001110, 6'b001011};
        load_valid = 0; load_instr = '0; clear = 0; start = 0; reps = '0; abort = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // reset values, then core_reset drops on the first clock after release
        tick();
        chk("rst/vals", 32'({core_reset, busy, result_valid, core_instr, result, load_ready}),
            32'({1'b1, 1'b0, 1'b0, NOP, 8'h00, 1'b1}));
        reset_n = 1'b1;
        tick();
        chk("rst/release", 32'({core_reset, busy, core_instr}), 32'({1'b0, 1'b0, NOP}));

        // scenario 1: known program, result 5
        foreach (s1[i]) load1(s1[i]);
        run("s1", 4'd0, 1'b0, '0);
        chk("s1/five", 32'(result[5:0]), 32'(5));

        // scenario 2: state persists across runs; replay with reps
        do_clear();
        foreach (s2[i]) load1(s2[i]);
        run("s2a", 4'd0, 1'b0, '0);
        chk("s2a/six", 32'(result[5:0]), 32'(6));
        do_clear();
        load1(6'b001011);
        run("s2b", 4'd2, 1'b0, '0);

        // scenario 3: fill to DEPTH, extra load refused, exact issue
        do_clear();
        for (int i = 0; i < DEPTH; i++) load1(rnd_ins());
        chk("s3/full", 32'(load_ready), 32'(0));
        load1(rnd_ins());
        run("s3", 4'd0, 1'b0, '0);

        // scenario 4: empty start, clear beats load, start+load on empty
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s4/empty", 32'({busy, core_instr, core_reset}), 32'({1'b0, NOP, 1'b0}));
        clear = 1'b1; load_valid = 1'b1; load_instr = rnd_ins();
        #1 chk("s4/clr_ready", 32'(load_ready), 32'(0));
        tick();
        clear = 1'b0; load_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s4/clr_wins", 32'(busy), 32'(0));
        run("s4", 4'd0, 1'b1, rnd_ins());

        // scenario 5a: abort on RUN cycle 3 of 6
        do_clear();
        for (int i = 0; i < 6; i++) load1(rnd_ins());
        start = 1'b1; reps = 4'd0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("s5/c3", 32'(core_instr), 32'(prog[2]));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) ref_exec(prog[i]);
        chk("s5/abort", 32'({busy, core_instr, core_reset, result_valid}), 32'({1'b0, NOP, 1'b0, 1'b0}));
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("s5/quiet", 32'(bad), 32'(0));
        chk("s5/res_kept", 32'(result), 32'(last_res));
        run("s5/replay", 4'($urandom_range(2)), 1'b0, '0);

        // scenario 5b: async reset mid-run
        start = 1'b1; reps = 4'd1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("s5/rst", 32'({core_reset, busy, result_valid, core_instr, result}),
            32'({1'b1, 1'b0, 1'b0, NOP, 8'h00}));
        ref_exec(prog[0]);
        last_res = 8'h00;
        prog.delete();
        tick();
        reset_n = 1'b1;
        tick();
        chk("s5/rst_rel", 32'({core_reset, busy, load_ready}), 32'({1'b0, 1'b0, 1'b1}));

        // randomized programs, lengths and repeat counts
        for (int it = 0; it < 10; it++) begin
            do_clear();
            len = $urandom_range(DEPTH, 1);
            wl  = 1'($urandom_range(1));
            for (int i = 0; i < len - int'(wl); i++) load1(rnd_ins());
            run($sformatf("rnd%0d", it), 4'($urandom_range(3)), wl, rnd_ins());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
